// File: rtl/cursor_input_controller.sv
// rtl/cursor_input_controller.sv - button conditioning and cursor ownership for the 5x4 card grid
//
// Purpose: synchronises and debounces the three raw active-low buttons,
// auto-repeats the two move buttons, and keeps the registered cursor index
// (4*col + row, 0..19) for the game core.
//
// Ports:
//   clock_50M     in   system clock (only clock)
//   reset_n       in   asynchronous active-low reset
//   select_n      in   raw select button, 0 = pressed
//   move_x_n      in   raw column-move button, 0 = pressed
//   move_y_n      in   raw row-move button, 0 = pressed
//   cursor_pos    out  5-bit card index, 0..19
//   cursor_moved  out  one-cycle pulse on the edge cursor_pos changes
//   select_pulse  out  one-cycle pulse per accepted select press
//   select_held   out  debounced select level, 1 = pressed

// Synchroniser plus debouncer for one active-low button; level is 1 = pressed.
module cursor_input_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clock_50M,
  input  logic reset_n,
  input  logic raw_n,
  output logic level
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_n, sync2_n, stable_n;
  logic [DW-1:0] cnt;

  always_ff @(posedge clock_50M or negedge reset_n) begin
    if (!reset_n) begin
      sync1_n  <= 1'b1;
      sync2_n  <= 1'b1;
      stable_n <= 1'b1;
      cnt      <= '0;
    end else begin
      sync1_n <= raw_n;
      sync2_n <= sync1_n;
      if (sync2_n == stable_n) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        stable_n <= sync2_n;
        cnt      <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign level = ~stable_n;
endmodule

// Auto-repeat FSM for one move button. step is decoded from the current
// state so the cursor register can act on the same edge the FSM advances.
module cursor_repeat_fsm #(
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 10_000_000
) (
  input  logic clock_50M,
  input  logic reset_n,
  input  logic level,
  output logic step
);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

  state_t        state;
  logic          prev;
  logic [RW-1:0] cnt;
  logic          press;

  assign press = level & ~prev;

  // A release in DELAY/REPEAT suppresses the step because level gates it.
  always_comb begin
    step = 1'b0;
    case (state)
      IDLE:    step = press;
      DELAY:   step = level && (cnt == RD_LAST);
      REPEAT:  step = level && (cnt == RP_LAST);
      default: step = 1'b0;
    endcase
  end

  always_ff @(posedge clock_50M or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      prev  <= 1'b0;
      cnt   <= '0;
    end else begin
      prev <= level;
      case (state)
        IDLE: begin
          if (press) begin
            state <= DELAY;
            cnt   <= '0;
          end
        end
        DELAY: begin
          if (!level) begin
            state <= IDLE;
          end else if (cnt == RD_LAST) begin
            state <= REPEAT;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        REPEAT: begin
          if (!level) begin
            state <= IDLE;
          end else if (cnt == RP_LAST) begin
            cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

module cursor_input_controller #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD   = 10_000_000
) (
  input  logic       clock_50M,
  input  logic       reset_n,
  input  logic       select_n,
  input  logic       move_x_n,
  input  logic       move_y_n,
  output logic [4:0] cursor_pos,
  output logic       cursor_moved,
  output logic       select_pulse,
  output logic       select_held
);
  logic sel_level, x_level, y_level;
  logic sel_prev;
  logic step_x, step_y;
  logic [4:0] y_inc, after_y, next_pos;

  cursor_input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_sel (
    .clock_50M(clock_50M), .reset_n(reset_n), .raw_n(select_n), .level(sel_level));
  cursor_input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_x (
    .clock_50M(clock_50M), .reset_n(reset_n), .raw_n(move_x_n), .level(x_level));
  cursor_input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_y (
    .clock_50M(clock_50M), .reset_n(reset_n), .raw_n(move_y_n), .level(y_level));

  cursor_repeat_fsm #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_rep_x (
    .clock_50M(clock_50M), .reset_n(reset_n), .level(x_level), .step(step_x));
  cursor_repeat_fsm #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_rep_y (
    .clock_50M(clock_50M), .reset_n(reset_n), .level(y_level), .step(step_y));

  // Row advance wraps inside the column; column retreat wraps 0 -> 4.
  // A simultaneous pair applies the row step first, then the column step.
  always_comb begin
    y_inc    = cursor_pos + 5'd1;
    after_y  = cursor_pos;
    if (step_y) begin
      after_y = (y_inc[1:0] == 2'b00) ? (cursor_pos - 5'd3) : y_inc;
    end
    next_pos = after_y;
    if (step_x) begin
      next_pos = (after_y < 5'd4) ? (after_y + 5'd16) : (after_y - 5'd4);
    end
  end

  always_ff @(posedge clock_50M or negedge reset_n) begin
    if (!reset_n) begin
      cursor_pos   <= 5'd0;
      cursor_moved <= 1'b0;
      select_pulse <= 1'b0;
      select_held  <= 1'b0;
      sel_prev     <= 1'b0;
    end else begin
      cursor_pos   <= next_pos;
      cursor_moved <= step_x | step_y;
      sel_prev     <= sel_level;
      select_pulse <= sel_level & ~sel_prev;
      select_held  <= sel_level;
    end
  end
endmodule

// File: tb/tb_cursor_input_controller.sv
// tb/tb_cursor_input_controller.sv - scoreboard bench for cursor_input_controller
module tb_cursor_input_controller;
  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  logic       clock_50M = 1'b0;
  logic       reset_n   = 1'b0;
  logic       select_n  = 1'b1;
  logic       move_x_n  = 1'b1;
  logic       move_y_n  = 1'b1;
  logic [4:0] cursor_pos;
  logic       cursor_moved, select_pulse, select_held;

  cursor_input_controller #(
    .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clock_50M(clock_50M), .reset_n(reset_n), .select_n(select_n),
    .move_x_n(move_x_n), .move_y_n(move_y_n), .cursor_pos(cursor_pos),
    .cursor_moved(cursor_moved), .select_pulse(select_pulse), .select_held(select_held)
  );

  always #10 clock_50M = ~clock_50M;

  int cyc = 0;
  always @(posedge clock_50M) cyc++;

  typedef struct {
    bit         sel;
    logic [4:0] pos;
    int         edge_no;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input bit sel, input int pos, input int edge_no);
    exp_t e;
    e.sel     = sel;
    e.pos     = 5'(pos);
    e.edge_no = edge_no;
    q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock_50M);
  endtask

  // One short press of x and/or y; the step lands on edge k+6.
  task automatic tap(input bit x, input bit y, input int exp_pos);
    int k;
    k = cyc + 1;
    if (x) move_x_n = 1'b0;
    if (y) move_y_n = 1'b0;
    push(1'b0, exp_pos, k + 6);
    tick(5);
    move_x_n = 1'b1;
    move_y_n = 1'b1;
    tick(12);
  endtask

  // Monitor: every output pulse must match the head of the scoreboard.
  always @(negedge clock_50M) begin
    exp_t e;
    if (cursor_moved || select_pulse) begin
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_event: got moved=%0b sel=%0b pos=%0d at edge %0d, expected none",
                 cursor_moved, select_pulse, cursor_pos, cyc);
      end else begin
        e = q.pop_front();
        check("event_kind_select", int'(select_pulse), int'(e.sel));
        check("event_kind_moved", int'(cursor_moved), int'(!e.sel));
        if (!e.sel) check("cursor_pos", int'(cursor_pos), int'(e.pos));
        check("event_edge", cyc, e.edge_no);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout at edge %0d, expected finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int held_bad;

    // Reset values
    tick(2);
    check("reset_cursor_pos", int'(cursor_pos), 0);
    check("reset_cursor_moved", int'(cursor_moved), 0);
    check("reset_select_pulse", int'(select_pulse), 0);
    check("reset_select_held", int'(select_held), 0);
    reset_n = 1'b1;
    tick(3);

    // Glitches shorter than the debounce window, then a real 5-cycle press
    repeat (2) begin
      move_y_n = 1'b0; tick(3);
      move_y_n = 1'b1; tick(3);
    end
    k = cyc + 1;
    move_y_n = 1'b0;
    push(1'b0, 1, k + 6);
    tick(5);
    move_y_n = 1'b1;
    tick(12);

    // Wrap cases
    tap(0, 1, 2);
    tap(0, 1, 3);
    tap(0, 1, 0);
    tap(0, 1, 1);
    tap(0, 1, 2);
    tap(1, 0, 18);
    tap(1, 0, 14);
    tap(1, 0, 10);
    tap(1, 0, 6);
    tap(0, 1, 7);
    tap(1, 0, 3);
    tap(0, 1, 0);

    // Auto-repeat from pos 0, released before the step due at k+50
    k = cyc + 1;
    move_y_n = 1'b0;
    push(1'b0, 1, k + 6);
    push(1'b0, 2, k + 26);
    push(1'b0, 3, k + 34);
    push(1'b0, 0, k + 42);
    tick(44);
    move_y_n = 1'b1;
    tick(30);

    // Simultaneous steps from pos 3
    tap(0, 1, 1);
    tap(0, 1, 2);
    tap(0, 1, 3);
    tap(1, 1, 16);

    // Long select hold: one pulse, held level throughout
    k = cyc + 1;
    select_n = 1'b0;
    push(1'b1, 0, k + 6);
    tick(7);
    held_bad = 0;
    for (int i = 0; i < 93; i++) begin
      if (!select_held) held_bad++;
      tick(1);
    end
    check("select_held_throughout", held_bad, 0);

    // Asynchronous reset mid-cycle with select still held
    #3;
    reset_n = 1'b0;
    #1;
    check("async_reset_cursor_pos", int'(cursor_pos), 0);
    check("async_reset_select_held", int'(select_held), 0);
    check("async_reset_cursor_moved", int'(cursor_moved), 0);
    tick(3);
    reset_n = 1'b1;
    k = cyc + 1;
    push(1'b1, 0, k + 6);
    tick(10);
    check("select_held_after_reset", int'(select_held), 1);
    select_n = 1'b1;
    tick(15);
    check("select_held_released", int'(select_held), 0);

    for (int i = 0; i < 200 && q.size() != 0; i++) tick(1);
    check("pending_events", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
